// File: rtl/mmio_uart_pkg.sv
// mmio_uart_pkg: shared FSM state encoding, STATUS bit positions and default register addresses
package mmio_uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_BUSY = 2;
  localparam int ST_OVF = 3;
  localparam int ST_CNT = 4;
  localparam logic [31:0] DEF_TX_DATA_ADDR = 32'h1001_0020;
  localparam logic [31:0] DEF_STATUS_ADDR = 32'h1001_0024;
endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// sync_fifo: circular buffer (clk, reset, push/din in; pop in; dout, full, empty, count out); count kept apart from pointers
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: MMIO 8N1 UART transmitter (MemWrite/MemRead/Address/WriteData in; ReadData, Hit, Tx, TxBusy out)
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] TX_DATA_ADDR = DEF_TX_DATA_ADDR,
  parameter logic [31:0] STATUS_ADDR = DEF_STATUS_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic        Tx,
  output logic        TxBusy
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state;
  logic [BW-1:0] baud;
  logic [2:0] bit_idx;
  logic [7:0] sh, fifo_dout;
  logic [CW-1:0] count;
  logic [31:0] status;
  logic sel_tx, sel_st, full, empty, pop, baud_end, overflow, unused_wd;
  assign sel_tx = Address == TX_DATA_ADDR;
  assign sel_st = Address == STATUS_ADDR;
  assign Hit = sel_tx || sel_st;
  assign baud_end = baud == BW'(CLKS_PER_BIT - 1);
  // Pops only at frame boundaries: from IDLE, or at the last stop-bit cycle for gapless frames.
  assign pop = !empty && (state == IDLE || (state == STOP && baud_end));
  assign unused_wd = ^WriteData[31:8];
  always_comb begin
    status = '0;
    status[ST_EMPTY] = empty;
    status[ST_FULL] = full;
    status[ST_BUSY] = TxBusy;
    status[ST_OVF] = overflow;
    status[ST_CNT +: 4] = 4'(count);
  end
  assign ReadData = MemRead && sel_st ? status : '0;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk,
    .reset,
    .push(MemWrite && sel_tx),
    .pop,
    .din(WriteData[7:0]),
    .dout(fifo_dout),
    .full,
    .empty,
    .count
  );
  // A write while full is dropped unless the FSM pops in the same cycle.
  always_ff @(posedge clk or posedge reset)
    if (reset) overflow <= 1'b0;
    else if (MemWrite && sel_tx && full && !pop) overflow <= 1'b1;
    else if (MemWrite && sel_st && WriteData[ST_OVF]) overflow <= 1'b0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      baud <= '0;
      bit_idx <= '0;
      sh <= '0;
      Tx <= 1'b1;
      TxBusy <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (pop) begin
            sh <= fifo_dout;
            baud <= '0;
            state <= START;
            Tx <= 1'b0;
            TxBusy <= 1'b1;
          end
        START:
          if (baud_end) begin
            baud <= '0;
            bit_idx <= '0;
            state <= DATA;
            Tx <= sh[0];
          end else baud <= baud + BW'(1);
        DATA:
          if (baud_end) begin
            baud <= '0;
            sh <= sh >> 1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              Tx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              Tx <= sh[1];
            end
          end else baud <= baud + BW'(1);
        STOP:
          if (baud_end) begin
            baud <= '0;
            if (pop) begin
              sh <= fifo_dout;
              state <= START;
              Tx <= 1'b0;
            end else begin
              state <= IDLE;
              TxBusy <= 1'b0;
            end
          end else baud <= baud + BW'(1);
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: randomized self-checking bench with a serial-line frame decoder as reference
module tb_mmio_uart_tx;
  localparam int CPB = 4;
  localparam logic [31:0] TXA = 32'h1001_0020;
  localparam logic [31:0] STA = 32'h1001_0024;
  logic clk = 1'b0, reset = 1'b1, MemWrite = 1'b0, MemRead = 1'b0;
  logic [31:0] Address = '0, WriteData = '0;
  logic [31:0] ReadData;
  logic Hit, Tx, TxBusy;
  int checks = 0, failures = 0, rx_bad = 0, ms = -1;
  logic mprev = 1'b1;
  logic [7:0] mb;
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8), .TX_DATA_ADDR(TXA), .STATUS_ADDR(STA)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead), .Address(Address),
    .WriteData(WriteData), .ReadData(ReadData), .Hit(Hit), .Tx(Tx), .TxBusy(TxBusy)
  );

  // Line decoder: finds a falling edge, samples each bit mid-period, records the byte.
  always @(negedge clk) begin
    if (reset) begin
      ms = -1;
      mprev = 1'b1;
    end else if (ms < 0) begin
      if (mprev && !Tx) ms = 0;
      mprev = Tx;
    end else begin
      ms++;
      if (ms == 2 && Tx !== 1'b0) rx_bad++;
      else if (ms > 2 && ms < 38 && (ms - 2) % 4 == 0) mb[(ms - 2) / 4 - 1] = Tx;
      if (ms == 38) begin
        if (Tx !== 1'b1) rx_bad++;
        rx_q.push_back(mb);
        ms = -1;
        mprev = 1'b1;
      end
    end
  end

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    return i == 0 ? 1'b0 : i == 9 ? 1'b1 : b[i-1];
  endfunction

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    Address = a;
    MemRead = 1'b1;
    #1 v = ReadData;
    MemRead = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    MemWrite = 1'b1;
    Address = a;
    WriteData = d;
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    repeat (2) @(negedge clk);
    while (TxBusy && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    logic [31:0] v;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({Tx, TxBusy} !== 2'b10) begin failures++; $display("FAIL reset_pins: Tx/TxBusy=%b want 10", {Tx, TxBusy}); end
    reset = 1'b0;
    @(negedge clk);
    rd(STA, v);
    checks++;
    if (v !== 32'h1) begin failures++; $display("FAIL reset_status: got %h want 00000001", v); end
    rd(TXA, v);
    checks++;
    if (v !== 32'h0 || Hit !== 1'b1) begin failures++; $display("FAIL txdata_read: got %h hit=%b want 0 hit=1", v, Hit); end
    Address = STA;
    #1;
    checks++;
    if (ReadData !== 32'h0 || Hit !== 1'b1) begin failures++; $display("FAIL noread_status: got %h hit=%b want 0 hit=1", ReadData, Hit); end
    Address = 32'h1001_0028;
    MemRead = 1'b1;
    #1;
    checks++;
    if (ReadData !== 32'h0 || Hit !== 1'b0) begin failures++; $display("FAIL miss_addr: got %h hit=%b want 0 hit=0", ReadData, Hit); end
    MemRead = 1'b0;
  endtask

  task automatic test_single(input logic [7:0] b);
    logic [31:0] v;
    rx_q.delete();
    @(negedge clk);
    MemWrite = 1'b1;
    Address = TXA;
    WriteData = {24'($urandom), b};
    @(negedge clk);
    MemWrite = 1'b0;
    rd(STA, v);
    checks++;
    if ({Tx, TxBusy, v} !== {2'b10, 32'h10}) begin failures++; $display("FAIL single_pushed: Tx=%b busy=%b status=%h want 1 0 00000010", Tx, TxBusy, v); end
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clk);
      checks++;
      if ({Tx, TxBusy} !== {frame_bit(b, i / CPB), 1'b1}) begin
        failures++;
        $display("FAIL single_line[%0d] byte %h: Tx/busy=%b want %b1", i, b, {Tx, TxBusy}, frame_bit(b, i / CPB));
      end
      if (i == 0) begin
        rd(STA, v);
        checks++;
        if (v !== 32'h5) begin failures++; $display("FAIL single_popped: status=%h want 00000005", v); end
      end
    end
    @(negedge clk);
    rd(STA, v);
    checks++;
    if ({Tx, TxBusy, v} !== {2'b10, 32'h1}) begin failures++; $display("FAIL single_end: Tx=%b busy=%b status=%h want 1 0 00000001", Tx, TxBusy, v); end
    checks++;
    if (rx_q.size() !== 1) begin failures++; $display("FAIL single_rx_count: got %0d want 1", rx_q.size()); end
    else if (rx_q[0] !== b) begin failures++; $display("FAIL single_rx_byte: got %h want %h", rx_q[0], b); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp[2];
    exp[0] = 8'hA5;
    exp[1] = 8'h3C;
    rx_q.delete();
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      MemWrite = 1'b1;
      Address = TXA;
      WriteData = {24'h0, exp[j]};
    end
    @(negedge clk);
    MemWrite = 1'b0;
    for (int i = 0; i < 20 * CPB; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if ({Tx, TxBusy} !== {frame_bit(exp[i / (10 * CPB)], (i / CPB) % 10), 1'b1}) begin
        failures++;
        $display("FAIL b2b_line[%0d]: Tx/busy=%b want %b1", i, {Tx, TxBusy}, frame_bit(exp[i / (10 * CPB)], (i / CPB) % 10));
      end
    end
    @(negedge clk);
    checks++;
    if (TxBusy !== 1'b0) begin failures++; $display("FAIL b2b_end: busy=%b want 0", TxBusy); end
    checks++;
    if (rx_q.size() !== 2) begin failures++; $display("FAIL b2b_rx_count: got %0d want 2", rx_q.size()); end
    else if (rx_q[0] !== exp[0] || rx_q[1] !== exp[1]) begin failures++; $display("FAIL b2b_rx: got %h %h want a5 3c", rx_q[0], rx_q[1]); end
  endtask

  task automatic test_fill_overflow;
    logic [31:0] v;
    rx_q.delete();
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      MemWrite = 1'b1;
      Address = TXA;
      WriteData = {24'($urandom), 8'(k)};
    end
    @(negedge clk);
    MemWrite = 1'b0;
    rd(STA, v);
    checks++;
    if (v !== 32'h86) begin failures++; $display("FAIL fill_status: got %h want 00000086", v); end
    wr(TXA, 32'h0A);
    rd(STA, v);
    checks++;
    if (v !== 32'h8E) begin failures++; $display("FAIL overflow_status: got %h want 0000008e", v); end
    wr(STA, 32'h0);
    rd(STA, v);
    checks++;
    if (v !== 32'h8E) begin failures++; $display("FAIL clear_zero: got %h want 0000008e", v); end
    wr(STA, $urandom | 32'h8);
    rd(STA, v);
    checks++;
    if (v !== 32'h86) begin failures++; $display("FAIL clear_ovf: got %h want 00000086", v); end
    wait_idle(9 * 10 * CPB + 50);
    rd(STA, v);
    checks++;
    if ({TxBusy, v} !== {1'b0, 32'h1}) begin failures++; $display("FAIL fill_drain: busy=%b status=%h want 0 00000001", TxBusy, v); end
    checks++;
    if (rx_q.size() !== 9) begin failures++; $display("FAIL fill_rx_count: got %0d want 9", rx_q.size()); end
    else
      for (int k = 0; k < 9; k++) begin
        checks++;
        if (rx_q[k] !== 8'(k + 1)) begin failures++; $display("FAIL fill_rx[%0d]: got %h want %h", k, rx_q[k], 8'(k + 1)); end
      end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] v;
    int bad = 0;
    rx_q.delete();
    @(negedge clk);
    MemWrite = 1'b1;
    Address = TXA;
    WriteData = 32'hF0;
    @(negedge clk);
    WriteData = 32'h11;
    @(negedge clk);
    WriteData = 32'h22;
    @(negedge clk);
    MemWrite = 1'b0;
    repeat (16) @(negedge clk);
    rd(STA, v);
    checks++;
    if ({Tx, TxBusy, v} !== {2'b01, 32'h24}) begin failures++; $display("FAIL midframe_pre: Tx=%b busy=%b status=%h want 0 1 00000024", Tx, TxBusy, v); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({Tx, TxBusy} !== 2'b10) begin failures++; $display("FAIL async_reset: Tx/busy=%b want 10", {Tx, TxBusy}); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rd(STA, v);
    checks++;
    if (v !== 32'h1) begin failures++; $display("FAIL midframe_status: got %h want 00000001", v); end
    repeat (100) begin
      @(negedge clk);
      if (Tx !== 1'b1 || TxBusy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0 || rx_q.size() !== 0) begin failures++; $display("FAIL midframe_quiet: active cycles=%0d frames=%0d want 0 0", bad, rx_q.size()); end
  endtask

  task automatic test_random(input int rounds);
    logic [31:0] v;
    logic [7:0] b;
    logic [7:0] exp[$];
    for (int r = 0; r < rounds; r++) begin
      int k = $urandom_range(1, 8);
      rx_q.delete();
      exp.delete();
      for (int j = 0; j < k; j++) begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          MemWrite = 1'b0;
        end
        @(negedge clk);
        b = 8'($urandom);
        MemWrite = 1'b1;
        Address = TXA;
        WriteData = {24'($urandom), b};
        exp.push_back(b);
      end
      @(negedge clk);
      MemWrite = 1'b0;
      wait_idle(k * 10 * CPB + 100);
      rd(STA, v);
      checks++;
      if ({TxBusy, v} !== {1'b0, 32'h1}) begin failures++; $display("FAIL rand%0d_idle: busy=%b status=%h want 0 00000001", r, TxBusy, v); end
      checks++;
      if (rx_q.size() !== exp.size()) begin failures++; $display("FAIL rand%0d_count: got %0d want %0d", r, rx_q.size(), exp.size()); end
      else
        for (int j = 0; j < exp.size(); j++) begin
          checks++;
          if (rx_q[j] !== exp[j]) begin failures++; $display("FAIL rand%0d_byte[%0d]: got %h want %h", r, j, rx_q[j], exp[j]); end
        end
    end
    checks++;
    if (rx_bad !== 0) begin failures++; $display("FAIL framing: bad start/stop bits=%0d want 0", rx_bad); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single(8'h55);
    test_single(8'($urandom));
    test_single(8'($urandom));
    test_back_to_back;
    test_fill_overflow;
    test_reset_mid_frame;
    test_random(6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
